// File: rtl/banked_cache_mem_pkg.sv
// Shared types and address-field helpers for the banked cached memory.
// Fields are extracted from a zero-extended 32-bit address; callers truncate.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM    = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int STAT_WIDTH = 32;

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int index_width);
    return addr & ((32'd1 << index_width) - 32'd1);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int index_width);
    return addr >> index_width;
  endfunction

  // With a single bank there is no select field at all.
  function automatic logic [31:0] get_bank(input logic [31:0] addr, input int addr_width,
                                           input int bank_bits);
    if (bank_bits == 0) return '0;
    return addr >> (addr_width - bank_bits);
  endfunction

endpackage

// File: rtl/banked_cache_mem_if.sv
// Request/response bus of the cached memory.
// Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1;
// the requester holds req_valid and its fields stable until then. rsp_valid is a
// one-cycle pulse with no backpressure; rsp_rdata is meaningful only while it is high.
interface banked_cache_mem_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/banked_cache_mem_bank.sv
// One backing bank: single-port array with synchronous write and registered read.
// Contents are intentionally not reset.
module mem_bank #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/banked_cache_mem.sv
// Direct-mapped, write-through, one-word-per-line cache over NUM_BANKS backing banks.
// Optional read hit/miss statistics are built when MEM_STATS_EN is defined.
module banked_cache_mem
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_BANKS   = 2,
  parameter int INDEX_WIDTH = 7,
  parameter int MEM_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  banked_cache_mem_if.slave        bus,
  output state_t                   dbg_state
`ifdef MEM_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]    hit_count,
  output logic [STAT_WIDTH-1:0]    miss_count
`endif
);
  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int BANK_SEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int LOCAL_AW   = ADDR_WIDTH - BANK_BITS;
  localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH;
  localparam int CNT_W      = $clog2(MEM_LATENCY + 1);

  state_t                  state;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [CNT_W-1:0]        cnt;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic [DATA_WIDTH-1:0]   c_data [2**INDEX_WIDTH];
  logic [TAG_WIDTH-1:0]    c_tag  [2**INDEX_WIDTH];
  logic [2**INDEX_WIDTH-1:0] c_valid;

  logic [INDEX_WIDTH-1:0]  idx;
  logic [TAG_WIDTH-1:0]    tag;
  logic [BANK_SEL_W-1:0]   bank;
  logic                    hit;
  logic                    mem_exit;
  logic [DATA_WIDTH-1:0]   bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   sel_rdata;

  assign idx       = INDEX_WIDTH'(get_index(32'(r_addr), INDEX_WIDTH));
  assign tag       = TAG_WIDTH'(get_tag(32'(r_addr), INDEX_WIDTH));
  assign bank      = BANK_SEL_W'(get_bank(32'(r_addr), ADDR_WIDTH, BANK_BITS));
  assign hit       = c_valid[idx] && (c_tag[idx] == tag);
  assign mem_exit  = (state == MEM) && (cnt == '0) && !rst;
  assign sel_rdata = bank_rdata[bank];

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state;

  // The request address is held from LOOKUP onwards, so the registered bank
  // read is already valid in the first MEM cycle even for MEM_LATENCY = 1.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(.AW(LOCAL_AW), .DW(DATA_WIDTH)) u_bank (
      .clk  (clk),
      .we   (mem_exit && r_we && (bank == BANK_SEL_W'(g))),
      .addr (r_addr[LOCAL_AW-1:0]),
      .wdata(r_wdata),
      .rdata(bank_rdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          r_we    <= bus.req_we;
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          state   <= LOOKUP;
        end
        LOOKUP: if (!r_we && hit) begin
          rsp_rdata_q <= c_data[idx];
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end else begin
          cnt   <= CNT_W'(MEM_LATENCY - 1);
          state <= MEM;
        end
        MEM: if (cnt == '0) begin
          rsp_rdata_q <= r_we ? r_wdata : sel_rdata;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) c_valid <= '0;
    else if (mem_exit && !r_we) c_valid[idx] <= 1'b1;
  end

  // Read misses allocate; writes only update a line they already hit.
  always_ff @(posedge clk) begin
    if (mem_exit && (!r_we || hit)) begin
      c_data[idx] <= r_we ? r_wdata : sel_rdata;
      c_tag[idx]  <= tag;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP && !r_we) begin
      if (hit && hit_count != '1)        hit_count  <= hit_count + 1'b1;
      else if (!hit && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_banked_cache_mem.sv
// Self-checking bench for banked_cache_mem: directed scenarios then randomized traffic
// against a line-level cache/memory reference model. Build with MEM_STATS_EN to check statistics.
module tb_banked_cache_mem;
  import mem_pkg::*;

  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
`ifdef MEM_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  banked_cache_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  banked_cache_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(2), .INDEX_WIDTH(7), .MEM_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
`ifdef MEM_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: backing memory, cache lines, statistics
  logic [DW-1:0] m_mem   [int];
  logic          m_valid [128];
  logic [5:0]    m_tag   [128];
  logic [DW-1:0] m_line  [128];
  int            m_hits;
  int            m_misses;
  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef MEM_STATS_EN
    check({tag, "_hits"}, hit_count, 32'(m_hits));
    check({tag, "_misses"}, miss_count, 32'(m_misses));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // driver: issue one request, then measure latency, data and ready behaviour
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input bit noise, input string tag);
    int            idx, lat, got_k, k;
    bit            hit, ready_bad;
    logic [DW-1:0] exp_d, got_d;
    idx = int'(addr) % 128;
    hit = m_valid[idx] && (m_tag[idx] == 6'(addr >> 7));
    lat = (!we && hit) ? 2 : 2 + LAT;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
    if (we) begin
      m_mem[int'(addr)] = wdata;
      if (hit) m_line[idx] = wdata;
      exp_d = wdata;
    end else if (hit) begin
      exp_d = m_line[idx];
      m_hits++;
    end else begin
      exp_d = m_mem[int'(addr)];
      m_valid[idx] = 1'b1;
      m_tag[idx]   = 6'(addr >> 7);
      m_line[idx]  = exp_d;
      m_misses++;
    end
    exp_q.push_back(exp_d);
    got_k = 0;
    got_d = '0;
    ready_bad = 1'b0;
    for (int c = 1; c <= lat + 4 && got_k == 0; c++) begin
      @(negedge clk);
      if (noise) begin
        bus.req_addr = AW'($urandom_range(0, 8191));
        bus.req_we   = 1'b0;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.rsp_valid) begin
        got_k = c;
        got_d = bus.rsp_rdata;
      end
      if (bus.req_ready) ready_bad = 1'b1;
    end
    check({tag, "_latency"}, 32'(got_k), 32'(lat));
    check({tag, "_rdata"}, 32'(got_d), 32'(exp_q.pop_front()));
    check({tag, "_busy_ready"}, 32'(ready_bad), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check_stats("post_rst");
  endtask

  logic [AW-1:0] pool [16];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_reset();
    apply_reset(3);

    // write, miss, hit
    do_req(1'b1, 13'h0005, 16'hBEEF, 1'b0, "t1_wr");
    do_req(1'b0, 13'h0005, 16'h0000, 1'b0, "t1_rd_miss");
    do_req(1'b0, 13'h0005, 16'h0000, 1'b0, "t1_rd_hit");
    check_stats("t1");

    // index conflict: write does not allocate
    do_req(1'b1, 13'h0085, 16'h1234, 1'b0, "t2_wr");
    do_req(1'b0, 13'h0005, 16'h0000, 1'b0, "t2_rd_hit");
    do_req(1'b0, 13'h0085, 16'h0000, 1'b0, "t2_rd_conf");
    do_req(1'b0, 13'h0005, 16'h0000, 1'b0, "t2_rd_back");

    // bank select from the address MSB
    do_req(1'b1, 13'h1003, 16'hA5A5, 1'b0, "t3_wr_b1");
    do_req(1'b1, 13'h0003, 16'h5A5A, 1'b0, "t3_wr_b0");
    do_req(1'b0, 13'h1003, 16'h0000, 1'b0, "t3_rd_b1");
    do_req(1'b0, 13'h0003, 16'h0000, 1'b0, "t3_rd_b0");

    // write-update of a resident line
    do_req(1'b1, 13'h0010, 16'h0BAD, 1'b0, "t4_init");
    do_req(1'b0, 13'h0010, 16'h0000, 1'b0, "t4_fill");
    do_req(1'b1, 13'h0010, 16'hCAFE, 1'b0, "t4_upd");
    do_req(1'b0, 13'h0010, 16'h0000, 1'b0, "t4_rd_hit");

    // reset in the first MEM cycle abandons the write
    do_req(1'b1, 13'h0020, 16'h2222, 1'b0, "t5_init");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 13'h0020;
    bus.req_wdata = 16'h1111;
    check("t5_accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    model_reset();
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (bus.rsp_valid) seen = 1'b1;
        @(negedge clk);
      end
      check("t5_no_rsp", 32'(seen), 32'd0);
    end
    check_stats("t5");
    do_req(1'b0, 13'h0020, 16'h0000, 1'b0, "t5_rd");

    // requests held during a miss are ignored until IDLE
    do_req(1'b0, 13'h1003, 16'h0000, 1'b1, "t6_noise_miss");
    do_req(1'b0, 13'h0085, 16'h0000, 1'b1, "t6_noise_next");

    // randomized traffic over a conflicting address pool
    for (int i = 0; i < 16; i++) begin
      pool[i] = {1'(i & 1), 5'($urandom_range(0, 31)), 7'(8'h40 + (i % 3))};
      do_req(1'b1, pool[i], 16'($urandom), 1'b0, "rnd_init");
    end
    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) < 3)
        do_req(1'b1, a, 16'($urandom), $urandom_range(0, 1) == 1, "rnd_wr");
      else
        do_req(1'b0, a, 16'h0000, $urandom_range(0, 1) == 1, "rnd_rd");
    end
    check_stats("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banked_cache_mem.md
# banked_cache_mem

Parametrised cached memory subsystem: a direct-mapped, write-through, one-word-per-line cache in front of a banked backing store of `NUM_BANKS` synchronous-write arrays. Bank select is decoded from the address MSBs. All traffic uses a valid/ready request channel and a one-cycle response pulse. It replaces the fixed two-bank, fixed-width memory wrapper and adds real hit/miss handling with a configurable backing latency.

## Interface
Parameters:
- `ADDR_WIDTH`, 13, word address width.
- `DATA_WIDTH`, 16, word width.
- `NUM_BANKS`, 2, backing banks; power of 2, ≥1. Bank = `addr[ADDR_WIDTH-1 -: $clog2(NUM_BANKS)]`.
- `INDEX_WIDTH`, 7, cache index bits. Index = `addr[INDEX_WIDTH-1:0]`; tag = `addr[ADDR_WIDTH-1:INDEX_WIDTH]`.
- `MEM_LATENCY`, 2, backing access cycles; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE and while `rst`=0.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_WIDTH`: word address.
- `req_wdata` in `DATA_WIDTH`: write data.
- `rsp_valid` out 1: one-cycle completion pulse, for both reads and writes.
- `rsp_rdata` out `DATA_WIDTH`: read data; for a write, the written data.
- `hit_count`, `miss_count` out 32: read statistics; present only with `MEM_STATS_EN`.

## Operation
- FSM states: IDLE → LOOKUP → (RESP | MEM → RESP) → IDLE.
- IDLE: when `req_valid & req_ready`, register we/addr/wdata and go to LOOKUP.
- LOOKUP: hit = `valid[index] & (tag_arr[index]==tag)`.
  - Read hit: load `rsp_rdata` from the cache data array and go to RESP.
  - Read miss or any write: go to MEM and load the latency counter with `MEM_LATENCY-1`.
- MEM: decrement the counter each cycle. On the edge leaving MEM (counter = 0):
  - Read: fetch the selected bank word into `rsp_rdata`, fill line (data, tag, valid=1), replacing any previous occupant.
  - Write: commit to the selected bank. If the line hit, update its data (write-update). If it missed, there is no allocate and the line is untouched.
  - Then go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- `req_valid` outside IDLE is ignored. The requester holds it until it sees ready.
- Backing arrays are not cleared by reset. Cache valid bits are all cleared.

## Timing
- Acceptance in cycle N means `req_valid & req_ready` are sampled at the end of cycle N.
- Read hit: `rsp_valid` in cycle N+2; `req_ready` is back in N+3.
- Read miss or write: `rsp_valid` in cycle N+2+`MEM_LATENCY`.
- `req_ready`=0 from N+1 through the RESP cycle.
- Reset values:
  - state IDLE, all `valid`=0.
  - `req_ready`=0 while `rst` high, 1 in the first cycle after.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - counters = 0.
- Reset mid-operation: the transaction is abandoned. No bank write or cache fill occurs unless the MEM-exit edge has already passed, and no `rsp_valid` is produced.
- Rst and acceptance in the same cycle: reset wins and the request is not accepted.

## Configuration
- `MEM_STATS_EN` defined:
  - `hit_count` increments on each read hit in LOOKUP; `miss_count` increments on each read miss.
  - Writes are not counted.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and reset to 0.
- Not defined: both ports and all counter logic are absent.

## Structure
- Package `mem_pkg`:
  - state enum typedef (IDLE, LOOKUP, MEM, RESP).
  - `STAT_WIDTH`=32.
  - helper functions for tag, index and bank field extraction.
- Sub-module `mem_bank`: single-port array of `2**(ADDR_WIDTH-$clog2(NUM_BANKS))` × `DATA_WIDTH`, with synchronous write and registered read. Instantiated `NUM_BANKS` times by generate; the top level muxes read data by bank.
- Cache tag, data and valid arrays are local to the top level.

## Test plan
Defaults: index `addr[6:0]`, tag `addr[12:7]`, bank `addr[12]`.
1. Write/read/hit:
   - Write 0x0005 ← 0xBEEF accepted at N → `rsp_valid` at N+4.
   - Read 0x0005 (miss) → 0xBEEF at N+4.
   - Read 0x0005 again (hit) → 0xBEEF at N+2.
   - With stats: hit=1, miss=1.
2. Conflict:
   - Write 0x0085 ← 0x1234 (same index, no allocate), then read 0x0005 → hit returning 0xBEEF.
   - Read 0x0085 → miss returning 0x1234.
   - Read 0x0005 → miss returning 0xBEEF.
3. Banks: write 0x1003 ← 0xA5A5 and 0x0003 ← 0x5A5A → reads return 0xA5A5 and 0x5A5A respectively.
4. Write update: read 0x0010 to fill the line, write 0x0010 ← 0xCAFE, read 0x0010 → hit, 0xCAFE at N+2.
5. Reset abort:
   - Set 0x0020 = 0x2222.
   - Start write 0x0020 ← 0x1111, assert `rst` in the first MEM cycle → no `rsp_valid`.
   - Read 0x0020 afterwards → miss returning 0x2222.
6. Handshake: hold `req_valid` high with changing addresses during a miss → only the first request is accepted; the next is accepted in the cycle after RESP.
